// File: rtl/alu_cmd_issuer_if.sv
// Stream bundle between alu_cmd_issuer and its neighbours: command in, ALU drive/return, response out.
// Signal names carry the direction as seen from the issuer (slave side).
interface alu_cmd_issuer_if #(
  parameter int unsigned ARG_W  = 12,
  parameter int unsigned RES_W  = 10,
  parameter int unsigned OPER_W = 3,
  parameter int unsigned FLAG_W = 4
);
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [ARG_W-1:0]  i_cmd_arg0;
  logic [ARG_W-1:0]  i_cmd_arg1;
  logic [OPER_W-1:0] i_cmd_oper;

  logic [ARG_W-1:0]  o_alu_arg0;
  logic [ARG_W-1:0]  o_alu_arg1;
  logic [OPER_W-1:0] o_alu_oper;
  logic [RES_W-1:0]  i_alu_result;
  logic [FLAG_W-1:0] i_alu_flag;

  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [RES_W-1:0]  o_rsp_result;
  logic [FLAG_W-1:0] o_rsp_flag;

  modport slave (
    input  i_cmd_valid, i_cmd_arg0, i_cmd_arg1, i_cmd_oper,
    input  i_alu_result, i_alu_flag, i_rsp_ready,
    output o_cmd_ready, o_alu_arg0, o_alu_arg1, o_alu_oper,
    output o_rsp_valid, o_rsp_result, o_rsp_flag
  );

  modport master (
    output i_cmd_valid, i_cmd_arg0, i_cmd_arg1, i_cmd_oper,
    output i_alu_result, i_alu_flag, i_rsp_ready,
    input  o_cmd_ready, o_alu_arg0, o_alu_arg1, o_alu_oper,
    input  o_rsp_valid, o_rsp_result, o_rsp_flag
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Sequential front end for a combinational ALU: registers one command at a time into the ALU,
// captures its result a cycle later into an in-order response FIFO, and counts error flags.
module alu_cmd_issuer #(
  parameter int unsigned ARG_W      = 12,
  parameter int unsigned RES_W      = 10,
  parameter int unsigned OPER_W     = 3,
  parameter int unsigned FLAG_W     = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  alu_cmd_issuer_if.slave      bus,
  output logic [ERR_W-1:0]     o_err_cnt,
  output logic                 o_busy
);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ERR_BIT = 3;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t            r_state, w_state_nxt;
  logic [ARG_W-1:0]  r_arg0, r_arg1;
  logic [OPER_W-1:0] r_oper;
  logic [RES_W-1:0]  r_mem_res  [FIFO_DEPTH];
  logic [FLAG_W-1:0] r_mem_flag [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr, w_rd_ptr_inc;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_cmd_ready, w_cmd_ready_nxt;
  logic              r_rsp_valid, r_busy;
  logic [RES_W-1:0]  r_head_res, w_head_res_nxt;
  logic [FLAG_W-1:0] r_head_flag, w_head_flag_nxt;
  logic [ERR_W-1:0]  r_err_cnt;
  logic              w_accept, w_push, w_pop;

  assign w_accept     = bus.i_cmd_valid && r_cmd_ready;
  assign w_push       = (r_state == S_ISSUE);
  assign w_pop        = bus.i_rsp_ready && (r_count != '0);
  assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

  // Next state, FIFO occupancy, ready and registered head selection
  always_comb begin
    w_state_nxt     = r_state;
    w_head_res_nxt  = r_head_res;
    w_head_flag_nxt = r_head_flag;
    w_count_nxt     = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Head follows the next-oldest entry, or the pushed data when it becomes the only entry
    if (w_pop) begin
      if (r_count > CNT_W'(1)) begin
        w_head_res_nxt  = r_mem_res[w_rd_ptr_inc];
        w_head_flag_nxt = r_mem_flag[w_rd_ptr_inc];
      end else if (w_push) begin
        w_head_res_nxt  = bus.i_alu_result;
        w_head_flag_nxt = bus.i_alu_flag;
      end
    end else if (w_push && (r_count == '0)) begin
      w_head_res_nxt  = bus.i_alu_result;
      w_head_flag_nxt = bus.i_alu_flag;
    end

    // Space for the single in-flight result is reserved before accepting
    w_cmd_ready_nxt = (w_state_nxt == S_IDLE) && (w_count_nxt < CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_arg0      <= '0;
      r_arg1      <= '0;
      r_oper      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_head_res  <= '0;
      r_head_flag <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_arg0 <= bus.i_cmd_arg0;
        r_arg1 <= bus.i_cmd_arg1;
        r_oper <= bus.i_cmd_oper;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      r_count     <= w_count_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= (w_count_nxt != '0);
      r_busy      <= (w_state_nxt == S_ISSUE) || (w_count_nxt != '0);
      r_head_res  <= w_head_res_nxt;
      r_head_flag <= w_head_flag_nxt;
      if (w_push && bus.i_alu_flag[ERR_BIT] && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  // Storage array needs no reset; validity is tracked by pointers and count
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_res[r_wr_ptr]  <= bus.i_alu_result;
      r_mem_flag[r_wr_ptr] <= bus.i_alu_flag;
    end
  end

  assign bus.o_cmd_ready  = r_cmd_ready;
  assign bus.o_alu_arg0   = r_arg0;
  assign bus.o_alu_arg1   = r_arg1;
  assign bus.o_alu_oper   = r_oper;
  assign bus.o_rsp_valid  = r_rsp_valid;
  assign bus.o_rsp_result = r_head_res;
  assign bus.o_rsp_flag   = r_head_flag;
  assign o_err_cnt        = r_err_cnt;
  assign o_busy           = r_busy;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a small behavioural ALU (add/sub/div) closing the loop.
module tb_alu_cmd_issuer;
  localparam int unsigned ARG_W  = 12;
  localparam int unsigned RES_W  = 10;
  localparam int unsigned OPER_W = 3;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned ERR_W  = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [ERR_W-1:0] err_cnt;
  logic             busy;
  int               n_chk = 0;
  int               n_fail = 0;
  int               acc_cnt = 0;
  logic [RES_W-1:0] rsp_q [$];
  logic signed [12:0] w_wide;
  logic             w_div0;
  logic [RES_W-1:0] w_res;

  always #5 clk = ~clk;

  alu_cmd_issuer_if #(.ARG_W(ARG_W), .RES_W(RES_W), .OPER_W(OPER_W), .FLAG_W(FLAG_W)) bus ();

  alu_cmd_issuer #(
    .ARG_W(ARG_W), .RES_W(RES_W), .OPER_W(OPER_W), .FLAG_W(FLAG_W),
    .FIFO_DEPTH(4), .ERR_W(ERR_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .o_err_cnt(err_cnt), .o_busy(busy)
  );

  // Reference ALU: 000 add, 001 sub, 101 div; flag[3] on overflow or divide-by-zero
  always_comb begin
    w_wide = '0;
    w_div0 = 1'b0;
    case (bus.o_alu_oper)
      3'b001: w_wide = 13'($signed(bus.o_alu_arg0)) - 13'($signed(bus.o_alu_arg1));
      3'b101: begin
        if (bus.o_alu_arg1 == '0) w_div0 = 1'b1;
        else w_wide = 13'($signed(bus.o_alu_arg0) / $signed(bus.o_alu_arg1));
      end
      default: w_wide = 13'($signed(bus.o_alu_arg0)) + 13'($signed(bus.o_alu_arg1));
    endcase
    w_res = w_wide[RES_W-1:0];
    bus.i_alu_result = w_res;
    bus.i_alu_flag[0] = w_res[RES_W-1];
    bus.i_alu_flag[2] = (w_res == '0);
    bus.i_alu_flag[1] = !w_res[RES_W-1] && (w_res != '0);
    bus.i_alu_flag[3] = w_div0 || (w_wide > 13'sd511) || (w_wide < -13'sd512);
  end

  // Handshake observers
  always @(posedge clk) begin
    if (bus.i_cmd_valid && bus.o_cmd_ready) acc_cnt++;
    if (bus.o_rsp_valid && bus.i_rsp_ready) rsp_q.push_back(bus.o_rsp_result);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [ARG_W-1:0] a0, input logic [ARG_W-1:0] a1, input logic [OPER_W-1:0] op);
    int n;
    n = 0;
    @(negedge clk);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_arg0  = a0;
    bus.i_cmd_arg1  = a1;
    bus.i_cmd_oper  = op;
    while (!bus.o_cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_wait_expired", 32'(n >= 100), 32'd0);
    @(posedge clk);
    #1 bus.i_cmd_valid = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_rsp_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_acc;
    int base_q;
    int k;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_arg0  = '0;
    bus.i_cmd_arg1  = '0;
    bus.i_cmd_oper  = '0;
    bus.i_rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid",  32'(bus.o_rsp_valid),  32'd0);
    check("rst_rsp_result", 32'(bus.o_rsp_result), 32'd0);
    check("rst_rsp_flag",   32'(bus.o_rsp_flag),   32'd0);
    check("rst_err_cnt",    32'(err_cnt),          32'd0);
    check("rst_busy",       32'(busy),             32'd0);
    check("rst_cmd_ready",  32'(bus.o_cmd_ready),  32'd0);
    check("rst_alu_arg0",   32'(bus.o_alu_arg0),   32'd0);
    @(negedge clk) rst_n = 1'b1;

    // ADD 100+50
    send(12'd100, 12'd50, 3'b000);
    check("add_alu_arg0",     32'(bus.o_alu_arg0),  32'd100);
    check("add_alu_arg1",     32'(bus.o_alu_arg1),  32'd50);
    check("add_valid_issue",  32'(bus.o_rsp_valid), 32'd0);
    check("add_ready_issue",  32'(bus.o_cmd_ready), 32'd0);
    check("add_busy_issue",   32'(busy),            32'd1);
    @(posedge clk);
    #1;
    check("add_rsp_valid",  32'(bus.o_rsp_valid),  32'd1);
    check("add_rsp_result", 32'(bus.o_rsp_result), 32'd150);
    check("add_rsp_flag",   32'(bus.o_rsp_flag),   32'h2);
    check("add_err_cnt",    32'(err_cnt),          32'd0);
    pop_one();
    check("add_popped",   32'(bus.o_rsp_valid), 32'd0);
    check("add_alu_hold", 32'(bus.o_alu_arg0),  32'd100);
    check("add_idle_busy", 32'(busy),           32'd0);

    // Divide by zero
    send(12'd7, 12'd0, 3'b101);
    @(posedge clk);
    #1;
    check("div0_result", 32'(bus.o_rsp_result), 32'd0);
    check("div0_flag",   32'(bus.o_rsp_flag),   32'hC);
    check("div0_err",    32'(err_cnt),          32'd1);
    pop_one();

    // Backpressure: FIFO fills with 4, fifth held
    base_acc = acc_cnt;
    base_q   = rsp_q.size();
    @(negedge clk);
    bus.i_cmd_valid = 1'b1;
    for (int c = 0; c < 24; c++) begin
      k = acc_cnt - base_acc;
      bus.i_cmd_arg0 = ARG_W'((k + 1) * 10);
      bus.i_cmd_arg1 = 12'd1;
      bus.i_cmd_oper = 3'b000;
      @(negedge clk);
    end
    check("bp_accepted4", 32'(acc_cnt - base_acc), 32'd4);
    check("bp_ready_low", 32'(bus.o_cmd_ready),   32'd0);
    check("bp_head",      32'(bus.o_rsp_result),  32'd11);
    bus.i_rsp_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      k = acc_cnt - base_acc;
      if (k >= 5) bus.i_cmd_valid = 1'b0;
      else begin
        bus.i_cmd_arg0 = ARG_W'((k + 1) * 10);
        bus.i_cmd_arg1 = 12'd1;
      end
      if (k >= 5 && (rsp_q.size() - base_q) >= 5) break;
      @(negedge clk);
    end
    bus.i_cmd_valid = 1'b0;
    bus.i_rsp_ready = 1'b0;
    check("bp_accepted5", 32'(acc_cnt - base_acc),     32'd5);
    check("bp_rsp_count", 32'(rsp_q.size() - base_q),  32'd5);
    for (int i = 0; i < 5; i++) begin
      if (base_q + i < rsp_q.size())
        check($sformatf("bp_order_%0d", i), 32'(rsp_q[base_q + i]), 32'((i + 1) * 10 + 1));
    end

    // Push and pop on the same edge with one entry resident
    @(negedge clk);
    send(12'd200, 12'd1, 3'b000);
    @(posedge clk);
    #1;
    check("sim_first_head", 32'(bus.o_rsp_result), 32'd201);
    send(12'd300, 12'd2, 3'b000);
    bus.i_rsp_ready = 1'b1;
    base_q = rsp_q.size();
    @(posedge clk);
    #1;
    check("sim_valid", 32'(bus.o_rsp_valid),  32'd1);
    check("sim_head",  32'(bus.o_rsp_result), 32'd302);
    check("sim_flag",  32'(bus.o_rsp_flag),   32'h2);
    check("sim_popped_first", 32'(rsp_q[rsp_q.size() - 1]), 32'd201);
    @(posedge clk);
    #1;
    check("sim_empty",  32'(bus.o_rsp_valid), 32'd0);
    check("sim_popped_second", 32'(rsp_q[rsp_q.size() - 1]), 32'd302);
    check("sim_pop_count", 32'(rsp_q.size() - base_q), 32'd2);
    bus.i_rsp_ready = 1'b0;

    // Reset during ISSUE
    send(12'd5, 12'd3, 3'b000);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("rst_mid_arg0",  32'(bus.o_alu_arg0),  32'd0);
    check("rst_mid_err",   32'(err_cnt),         32'd0);
    check("rst_mid_busy",  32'(busy),            32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_stale", 32'(bus.o_rsp_valid), 32'd0);
    check("rst_ready",    32'(bus.o_cmd_ready), 32'd1);

    // Error counter saturation
    bus.i_rsp_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      send(12'd7, 12'd0, 3'b101);
      if (i == 253) begin
        @(posedge clk);
        #1;
        check("sat_254", 32'(err_cnt), 32'd254);
      end
      if (i == 254) begin
        @(posedge clk);
        #1;
        check("sat_255", 32'(err_cnt), 32'd255);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check("sat_hold",  32'(err_cnt),         32'd255);
    check("sat_drain", 32'(bus.o_rsp_valid), 32'd0);
    bus.i_rsp_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
